fp_mult_sched: RTL and testbench
================================

Name: fp_mult_sched

Overview:
Round-robin scheduler that shares one pipelined IEEE-754 single-precision multiplier among NREQ requesters.
- Accepts operand pairs over per-requester valid/ready handshakes and issues at most one multiply per cycle.
- Tracks the requester ID alongside the fixed-latency multiplier pipeline.
- Buffers results in a credit-protected FIFO and returns them on a single tagged response channel.
- Sits between client blocks and the registered fp_mult wrapper.

Parameters:
NREQ, 4, number of requesters (2..8)
LAT, 2, multiplier latency in cycles from mul_valid to mul_z/mul_status valid (>=1)
DEPTH, 4, result FIFO depth and maximum outstanding operations (>=1)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
req_valid  in  NREQ  per-requester operand valid
req_a  in  NREQ*32  operand A, requester i at bits [32i+31:32i]
req_b  in  NREQ*32  operand B, same packing
req_ready  out  NREQ  one-hot grant, at most one bit set
mul_valid  out  1  issue strobe to multiplier
mul_a  out  32  operand A to multiplier
mul_b  out  32  operand B to multiplier
mul_z  in  32  multiplier result, valid LAT cycles after issue
mul_status  in  8  multiplier status flags, aligned with mul_z
rsp_valid  out  1  response available
rsp_ready  in  1  consumer accepts response
rsp_id  out  IDW  requester index, IDW = max(1, clog2(NREQ))
rsp_z  out  32  product
rsp_status  out  8  status flags
busy  out  1  outstanding != 0

Behaviour:
- Reset: rst=1 at a clock edge has these effects.
  - Clears rr_ptr, tag pipeline, FIFO pointers and the outstanding counter.
  - After that edge, rsp_valid=0, busy=0, req_ready=0, mul_valid=0.
  - Reset mid-operation drops all in-flight and buffered results without emitting them.
- outstanding: count of issued operations not yet popped from the FIFO, width clog2(DEPTH+1).
  - Increments on issue, decrements on pop; unchanged when both occur in the same cycle.
- can_issue = (outstanding < DEPTH) or (pop this cycle).
- Arbitration is combinational from req_valid and rr_ptr.
  - Grant g is the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... mod NREQ.
  - req_ready[g]=1 only when can_issue=1 and rst=0; otherwise req_ready is all zero.
  - A requester must hold req_valid, req_a and req_b stable until its ready is seen.
- Issue (handshake req_valid[g] & req_ready[g]) behaves as follows.
  - mul_valid=1; mul_a/mul_b carry the granted operands combinationally in the same cycle.
  - rr_ptr <= (g+1) mod NREQ.
  - No issue means mul_valid=0 and rr_ptr unchanged.
  - mul_a/mul_b are don't-care when mul_valid=0.
- Tag pipeline: LAT-stage shift register of {vld, id}; stage 0 loads {issue, g} every cycle.
  - When stage LAT-1 shifts out with vld=1, {id, mul_z, mul_status} is written into the FIFO in that cycle.
  - This matches data arriving LAT cycles after mul_valid.
  - Write is always accepted; the credit rule guarantees space.
- FIFO: DEPTH entries, first-in first-out, registered storage.
  - rsp_valid = not empty; rsp_* come from the head entry.
  - Pop on rsp_valid & rsp_ready.
  - Simultaneous write and pop on a full FIFO is legal.
  - Write to an empty FIFO becomes visible on rsp_valid the next cycle (no bypass).
- Throughput: 1 op/cycle while rsp_ready=1 and DEPTH >= LAT+1.
  - Minimum request-to-response latency is LAT+1 cycles.
- Ordering: responses return in issue order.
- Fairness: a continuously asserting requester is granted at least once every NREQ issues.

Test Plan:
- Single op: req0 a=0x3F800000, b=0x40000000, bench multiplier returns 0x40000000 after LAT=2.
  - Required: req_ready[0] same cycle, mul_valid pulse, rsp_valid 3 cycles later with rsp_id=0, rsp_z=0x40000000, status passed through.
- Round-robin: all 4 req_valid held high, rsp_ready=1.
  - Required: grant order 0,1,2,3,0,..., one issue per cycle, responses in the same ID order.
- Backpressure/credits: rsp_ready=0, req1 continuously valid.
  - Required: exactly DEPTH=4 issues, then req_ready=0, busy=1.
  - Raise rsp_ready for one cycle: one pop and one new issue in the same cycle; outstanding stays 4.
- Skip idle requesters: only req2 and req3 valid, rr_ptr=0.
  - Required: grant 2, then 3, then 2; req_ready[0]/[1] never asserted.
- Reset mid-operation: rst asserted for one cycle with 3 ops in flight/buffered.
  - Required: rsp_valid=0, busy=0, rr_ptr=0 after the edge; no stale response ever appears.
  - A fresh op then completes normally with rsp_id correct.

Source files
------------

// File: rtl/fp_mult_sched.sv
// Round-robin front end that shares one fixed-latency pipelined FP multiplier
// among NREQ clients and returns tagged results through a credit-protected FIFO.
module fp_mult_sched #(
  parameter int NREQ  = 4,
  parameter int LAT   = 2,
  parameter int DEPTH = 4,
  localparam int IDW  = (NREQ > 2) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*32-1:0]   req_a,
  input  logic [NREQ*32-1:0]   req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic                 mul_valid,
  output logic [31:0]          mul_a,
  output logic [31:0]          mul_b,
  input  logic [31:0]          mul_z,
  input  logic [7:0]           mul_status,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [31:0]          rsp_z,
  output logic [7:0]           rsp_status,
  output logic                 busy
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [IDW-1:0] rr_ptr_reg;
  logic [CW-1:0]  outstanding_reg;
  logic [CW-1:0]  count_reg;
  logic [PW-1:0]  wr_ptr_reg;
  logic [PW-1:0]  rd_ptr_reg;

  logic           tag_vld_reg [LAT];
  logic [IDW-1:0] tag_id_reg  [LAT];

  logic [IDW-1:0] mem_id [DEPTH];
  logic [31:0]    mem_z  [DEPTH];
  logic [7:0]     mem_st [DEPTH];

  logic           found;
  logic [IDW-1:0] grant;
  logic [IDW-1:0] rr_next;
  int             arb_idx;
  logic           can_issue;
  logic           issue;
  logic           pop;
  logic           wr_en;

  // Search from the highest offset down so the nearest requester at or after rr_ptr wins.
  always_comb begin
    found   = 1'b0;
    grant   = '0;
    arb_idx = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      arb_idx = int'(rr_ptr_reg) + k;
      if (arb_idx >= NREQ) arb_idx = arb_idx - NREQ;
      if (req_valid[arb_idx]) begin
        found = 1'b1;
        grant = IDW'(arb_idx);
      end
    end
  end

  assign rsp_valid = (count_reg != '0);
  assign pop       = rsp_valid & rsp_ready;
  assign can_issue = (outstanding_reg < CW'(DEPTH)) || pop;
  assign req_ready = (found && can_issue && !rst) ? (NREQ'(1) << grant) : '0;
  assign issue     = |(req_valid & req_ready);
  assign mul_valid = issue;
  assign mul_a     = req_a[32*grant +: 32];
  assign mul_b     = req_b[32*grant +: 32];
  assign rr_next   = (grant == IDW'(NREQ - 1)) ? '0 : grant + IDW'(1);
  assign busy      = (outstanding_reg != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_reg <= '0;
    end else if (issue) begin
      rr_ptr_reg <= rr_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding_reg <= '0;
    end else if (issue && !pop) begin
      outstanding_reg <= outstanding_reg + CW'(1);
    end else if (pop && !issue) begin
      outstanding_reg <= outstanding_reg - CW'(1);
    end
  end

  // Tag pipeline mirrors the multiplier so the id meets its product on exit.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld_reg[0] <= 1'b0;
    end else begin
      tag_vld_reg[0] <= issue;
    end
    tag_id_reg[0] <= grant;
  end

  generate
    for (genvar gi = 1; gi < LAT; gi++) begin : g_tag
      always_ff @(posedge clk) begin
        if (rst) begin
          tag_vld_reg[gi] <= 1'b0;
        end else begin
          tag_vld_reg[gi] <= tag_vld_reg[gi-1];
        end
        tag_id_reg[gi] <= tag_id_reg[gi-1];
      end
    end
  endgenerate

  assign wr_en = tag_vld_reg[LAT-1];

  // Storage carries no reset; only the pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_id[wr_ptr_reg] <= tag_id_reg[LAT-1];
      mem_z[wr_ptr_reg]  <= mul_z;
      mem_st[wr_ptr_reg] <= mul_status;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_reg <= (wr_ptr_reg == PW'(DEPTH - 1)) ? '0 : wr_ptr_reg + PW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= (rd_ptr_reg == PW'(DEPTH - 1)) ? '0 : rd_ptr_reg + PW'(1);
      end
      if (wr_en && !pop) begin
        count_reg <= count_reg + CW'(1);
      end else if (pop && !wr_en) begin
        count_reg <= count_reg - CW'(1);
      end
    end
  end

  assign rsp_id     = mem_id[rd_ptr_reg];
  assign rsp_z      = mem_z[rd_ptr_reg];
  assign rsp_status = mem_st[rd_ptr_reg];

endmodule

// File: tb/tb_fp_mult_sched.sv
// Randomized bench for fp_mult_sched: a queue-based model predicts grants,
// credits and the tagged response stream cycle by cycle.
module tb_fp_mult_sched;

  localparam int NREQ  = 4;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;
  localparam int IDW   = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*32-1:0]  req_a;
  logic [NREQ*32-1:0]  req_b;
  logic [NREQ-1:0]     req_ready;
  logic                mul_valid;
  logic [31:0]         mul_a;
  logic [31:0]         mul_b;
  logic [31:0]         mul_z;
  logic [7:0]          mul_status;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [IDW-1:0]      rsp_id;
  logic [31:0]         rsp_z;
  logic [7:0]          rsp_status;
  logic                busy;

  always #5 clk = ~clk;

  fp_mult_sched #(.NREQ(NREQ), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .mul_valid(mul_valid), .mul_a(mul_a), .mul_b(mul_b),
    .mul_z(mul_z), .mul_status(mul_status),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_z(rsp_z), .rsp_status(rsp_status), .busy(busy)
  );

  // Stand-in multiplier: exact for 1.0*x, otherwise an arbitrary deterministic mix.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3F80_0000) return b;
    return (a * b) ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [7:0] fst(input logic [31:0] a, input logic [31:0] b);
    return a[31:24] ^ b[7:0];
  endfunction

  logic [31:0] pz [LAT];
  logic [7:0]  ps [LAT];
  always @(posedge clk) begin
    pz[0] <= fmul(mul_a, mul_b);
    ps[0] <= fst(mul_a, mul_b);
    for (int i = 1; i < LAT; i++) begin
      pz[i] <= pz[i-1];
      ps[i] <= ps[i-1];
    end
  end
  assign mul_z      = pz[LAT-1];
  assign mul_status = ps[LAT-1];

  typedef struct {
    int          id;
    logic [31:0] z;
    logic [7:0]  st;
    int          due;
  } rsp_t;

  rsp_t        infl[$];
  rsp_t        vis[$];
  int          rr_m = 0;
  int          cyc = 0;
  logic        pend [NREQ];
  logic [31:0] op_a [NREQ];
  logic [31:0] op_b [NREQ];
  int          n_vec = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic step(input logic [NREQ-1:0] want, input logic rdy, input logic rs);
    logic [NREQ-1:0] exp_ready;
    int   g;
    int   outs;
    bit   found, pop, can, iss;
    rsp_t e;
    for (int i = 0; i < NREQ; i++) begin
      if (!pend[i] && want[i]) begin
        pend[i] = 1'b1;
        op_a[i] = $urandom;
        op_b[i] = $urandom;
      end
      req_valid[i]       = pend[i];
      req_a[32*i +: 32]  = op_a[i];
      req_b[32*i +: 32]  = op_b[i];
    end
    rsp_ready = rdy;
    rst       = rs;
    #1;
    if (rs) begin
      chk("rst_req_ready", 64'(req_ready), 64'(0));
      chk("rst_mul_valid", 64'(mul_valid), 64'(0));
    end else begin
      found = 0;
      g     = 0;
      for (int k = 0; k < NREQ; k++) begin
        if (!found && pend[(rr_m + k) % NREQ]) begin
          found = 1;
          g     = (rr_m + k) % NREQ;
        end
      end
      outs      = infl.size() + vis.size();
      pop       = (vis.size() > 0) && rdy;
      can       = (outs < DEPTH) || pop;
      iss       = found && can;
      exp_ready = iss ? (NREQ'(1) << g) : '0;
      chk("rsp_valid", 64'(rsp_valid), 64'(vis.size() > 0));
      if (vis.size() > 0) begin
        chk("rsp_id", 64'(rsp_id), 64'(vis[0].id));
        chk("rsp_z", 64'(rsp_z), 64'(vis[0].z));
        chk("rsp_status", 64'(rsp_status), 64'(vis[0].st));
      end
      chk("busy", 64'(busy), 64'(outs != 0));
      chk("req_ready", 64'(req_ready), 64'(exp_ready));
      chk("mul_valid", 64'(mul_valid), 64'(iss));
      if (iss) begin
        chk("mul_a", 64'(mul_a), 64'(op_a[g]));
        chk("mul_b", 64'(mul_b), 64'(op_b[g]));
      end
      if (pop) void'(vis.pop_front());
      if (iss) begin
        e.id  = g;
        e.z   = fmul(op_a[g], op_b[g]);
        e.st  = fst(op_a[g], op_b[g]);
        e.due = cyc + LAT + 1;
        infl.push_back(e);
        pend[g] = 1'b0;
        rr_m    = (g + 1) % NREQ;
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (rs) begin
      infl.delete();
      vis.delete();
      rr_m = 0;
    end
    while (infl.size() > 0 && infl[0].due <= cyc) vis.push_back(infl.pop_front());
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      pend[i] = 1'b0;
      op_a[i] = '0;
      op_b[i] = '0;
    end
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    rst       = 1'b1;
    @(negedge clk);
    step('0, 1'b0, 1'b1);
    step('0, 1'b0, 1'b1);
    step('0, 1'b1, 1'b0);

    // Single op: 1.0 * 2.0 from requester 0
    pend[0] = 1'b1;
    op_a[0] = 32'h3F80_0000;
    op_b[0] = 32'h4000_0000;
    for (int i = 0; i < 6; i++) step('0, 1'b1, 1'b0);

    // Round-robin with all requesters busy
    for (int i = 0; i < 12; i++) step(4'hF, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) step('0, 1'b1, 1'b0);

    // Credit exhaustion, then a single pop-and-issue cycle
    for (int i = 0; i < 8; i++) step(4'h2, 1'b0, 1'b0);
    chk("bp_busy", 64'(busy), 64'(1));
    chk("bp_stalled", 64'(req_ready), 64'(0));
    step(4'h2, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(4'h2, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step('0, 1'b1, 1'b0);

    // Idle requesters skipped, starting from a freshly reset pointer
    step('0, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) step(4'hC, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) step('0, 1'b1, 1'b0);

    // Reset with three ops in flight or buffered
    for (int i = 0; i < 3; i++) step(4'h1, 1'b0, 1'b0);
    step('0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) step('0, 1'b1, 1'b0);
    step(4'h8, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step('0, 1'b1, 1'b0);

    // Random traffic and backpressure
    for (int i = 0; i < 400; i++) begin
      step(NREQ'($urandom), ($urandom_range(0, 3) != 0), 1'b0);
    end
    for (int i = 0; i < 20; i++) step('0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
